l1_i_controller_nway: RTL

Parametrised N-way set-associative L1 instruction-cache controller: tag/valid storage, hit detection, tree pseudo-LRU replacement, L2 refill handshake and a sequential flush walk. It sits between the fetch stage (C side) and the L2 controller. It drives stall, refill and way for the L1 data array. It generalises the 2-way controller to WAYS ways and adds flush-completion signalling.

---
 rtl/l1_i_controller_nway_pkg.sv | 14 +
 rtl/l1_i_controller_nway_if.sv | 32 +++
 rtl/l1_i_controller_nway_plru_tree.sv | 44 ++++
 rtl/l1_i_controller_nway.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/l1_i_controller_nway_pkg.sv
// Shared types and address-split constants for the N-way L1 instruction-cache controller.
package l1_i_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MISS   = 2'd1,
      ST_REFILL = 2'd2,
      ST_FLUSH  = 2'd3
   } state_e;

   localparam int OFFSET    = 6;
   localparam int ADDR_BITS = 26;

endpackage

// File: rtl/l1_i_controller_nway_if.sv
// Fetch-side and L2-side handshake bundle of the L1 instruction-cache controller.
interface l1_i_controller_nway_if #(
   parameter int TNUM   = 21,
   parameter int INUM   = 5,
   parameter int WAYS   = 4,
   parameter int TNUM_2 = 18,
   parameter int INUM_2 = 8
);
   logic [TNUM-1:0]         tag_C_L1;
   logic [INUM-1:0]         index_C_L1;
   logic                    read_C_L1;
   logic                    flush;
   logic                    ready_L2_L1;
   logic                    stall;
   logic                    refill;
   logic [$clog2(WAYS)-1:0] way;
   logic                    hit;
   logic                    read_L1_L2;
   logic [INUM_2-1:0]       index_L1_L2;
   logic [TNUM_2-1:0]       tag_L1_L2;
   logic                    flush_done;

   modport master (
      output tag_C_L1, index_C_L1, read_C_L1, flush, ready_L2_L1,
      input  stall, refill, way, hit, read_L1_L2, index_L1_L2, tag_L1_L2, flush_done
   );

   modport slave (
      input  tag_C_L1, index_C_L1, read_C_L1, flush, ready_L2_L1,
      output stall, refill, way, hit, read_L1_L2, index_L1_L2, tag_L1_L2, flush_done
   );
endinterface

// File: rtl/l1_i_controller_nway_plru_tree.sv
// Tree pseudo-LRU for one set: heap-ordered nodes, node n has children 2n+1 (lower) and 2n+2 (upper).
module plru_tree #(
   parameter int WAYS = 4
) (
   input  logic [WAYS-2:0]         bits,
   input  logic [$clog2(WAYS)-1:0] access_way,
   output logic [$clog2(WAYS)-1:0] victim,
   output logic [WAYS-2:0]         next_bits
);
   localparam int LVL = $clog2(WAYS);

   // Follow node bits from the root; a 0 bit sends the walk to the lower subtree.
   always_comb begin
      int   node;
      logic b;
      victim = '0;
      node   = 0;
      b      = 1'b0;
      for (int l = 0; l < LVL; l++) begin
         b = 1'b0;
         for (int n = 0; n < WAYS - 1; n++) begin
            b = (n == node) ? bits[n] : b;
         end
         victim[LVL-1-l] = b;
         node = 2 * node + (b ? 2 : 1);
      end
   end

   // Along the accessed path, point every node away from the accessed way.
   always_comb begin
      int   node;
      logic d;
      next_bits = bits;
      node      = 0;
      d         = 1'b0;
      for (int l = 0; l < LVL; l++) begin
         d = access_way[LVL-1-l];
         for (int n = 0; n < WAYS - 1; n++) begin
            next_bits[n] = (n == node) ? ~d : next_bits[n];
         end
         node = 2 * node + (d ? 2 : 1);
      end
   end
endmodule

// File: rtl/l1_i_controller_nway.sv
// N-way set-associative L1 instruction-cache controller: tags/valids in flops, tree PLRU,
// L2 refill handshake and a one-set-per-cycle flush walk.
module l1_i_controller_nway
   import l1_i_pkg::*;
#(
   parameter int TNUM   = 21,
   parameter int INUM   = 5,
   parameter int WAYS   = 4,
   parameter int TNUM_2 = 18,
   parameter int INUM_2 = 8
) (
   input  logic                 clk,
   input  logic                 nrst,
   l1_i_controller_nway_if.slave bus
);
   localparam int SETS  = 1 << INUM;
   localparam int WAY_W = $clog2(WAYS);
   localparam int NODES = WAYS - 1;

   state_e               state_r, state_s;
   logic [TNUM-1:0]      tag_r   [WAYS][SETS];
   logic [SETS-1:0]      valid_r [WAYS];
   logic [NODES-1:0]     plru_r  [SETS];
   logic [TNUM-1:0]      tag_req_r;
   logic [INUM-1:0]      index_req_r;
   logic [WAY_W-1:0]     victim_r;
   logic                 flush_pend_r;
   logic [INUM-1:0]      flush_idx_r;

   logic [WAYS-1:0]      match_s;
   logic                 hit_any_s;
   logic [WAY_W-1:0]     hit_way_s;
   logic [WAY_W-1:0]     inv_way_s;
   logic                 inv_found_s;
   logic [INUM-1:0]      plru_set_s;
   logic [NODES-1:0]     plru_bits_s;
   logic [NODES-1:0]     plru_next_s;
   logic [WAY_W-1:0]     plru_victim_s;
   logic [WAY_W-1:0]     access_way_s;
   logic [WAY_W-1:0]     victim_sel_s;
   logic [ADDR_BITS-1:0] req_addr_s;

   logic                 stall_s, refill_s, hit_s, read_l2_s, flush_done_s;
   logic [WAY_W-1:0]     way_s;
   logic                 plru_upd_s, miss_latch_s, refill_wr_s, flush_clr_s;

   // Tag compare across all ways of the addressed set, plus lowest-numbered invalid way.
   always_comb begin
      match_s     = '0;
      hit_way_s   = '0;
      inv_way_s   = '0;
      inv_found_s = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         match_s[w] = valid_r[w][bus.index_C_L1] && (tag_r[w][bus.index_C_L1] == bus.tag_C_L1);
         hit_way_s  = match_s[w] ? WAY_W'(w) : hit_way_s;
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         inv_way_s   = valid_r[w][bus.index_C_L1] ? inv_way_s : WAY_W'(w);
         inv_found_s = inv_found_s | ~valid_r[w][bus.index_C_L1];
      end
      hit_any_s = |match_s;
   end

   // One shared PLRU tree: the refill cycle addresses the latched set, IDLE the requested set.
   assign plru_set_s   = (state_r == ST_REFILL) ? index_req_r : bus.index_C_L1;
   assign plru_bits_s  = plru_r[plru_set_s];
   assign access_way_s = (state_r == ST_REFILL) ? victim_r : hit_way_s;
   assign victim_sel_s = inv_found_s ? inv_way_s : plru_victim_s;

   plru_tree #(.WAYS(WAYS)) u_plru (
      .bits       (plru_bits_s),
      .access_way (access_way_s),
      .victim     (plru_victim_s),
      .next_bits  (plru_next_s)
   );

   // Next-state and output decode.
   always_comb begin
      state_s      = state_r;
      stall_s      = 1'b0;
      refill_s     = 1'b0;
      hit_s        = 1'b0;
      way_s        = '0;
      read_l2_s    = 1'b0;
      flush_done_s = 1'b0;
      plru_upd_s   = 1'b0;
      miss_latch_s = 1'b0;
      refill_wr_s  = 1'b0;
      flush_clr_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.flush) begin
               stall_s = 1'b1;
               state_s = ST_FLUSH;
            end else if (bus.read_C_L1) begin
               if (hit_any_s) begin
                  hit_s      = 1'b1;
                  way_s      = hit_way_s;
                  plru_upd_s = 1'b1;
               end else begin
                  stall_s      = 1'b1;
                  miss_latch_s = 1'b1;
                  state_s      = ST_MISS;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_MISS: begin
            stall_s   = 1'b1;
            read_l2_s = 1'b1;
            if (bus.ready_L2_L1) begin
               state_s = ST_REFILL;
            end else begin
               state_s = ST_MISS;
            end
         end
         ST_REFILL: begin
            stall_s     = 1'b1;
            refill_s    = 1'b1;
            way_s       = victim_r;
            refill_wr_s = 1'b1;
            plru_upd_s  = 1'b1;
            if (flush_pend_r || bus.flush) begin
               state_s = ST_FLUSH;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            stall_s     = 1'b1;
            flush_clr_s = 1'b1;
            if (&flush_idx_r) begin
               flush_done_s = 1'b1;
               state_s      = ST_IDLE;
            end else begin
               state_s = ST_FLUSH;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Valid bits and PLRU state; refill and flush never occur in the same cycle.
   always_ff @(posedge clk) begin
      if (nrst) begin
         for (int w = 0; w < WAYS; w++) begin
            valid_r[w] <= '0;
         end
         for (int s = 0; s < SETS; s++) begin
            plru_r[s] <= '0;
         end
      end else begin
         if (refill_wr_s) begin
            valid_r[victim_r][index_req_r] <= 1'b1;
         end else if (flush_clr_s) begin
            for (int w = 0; w < WAYS; w++) begin
               valid_r[w][flush_idx_r] <= 1'b0;
            end
         end
         if (plru_upd_s) begin
            plru_r[plru_set_s] <= plru_next_s;
         end else if (flush_clr_s) begin
            plru_r[flush_idx_r] <= '0;
         end
      end
   end

   // Tag array; contents are only meaningful behind a set valid bit, so no reset.
   always_ff @(posedge clk) begin
      if (refill_wr_s) begin
         tag_r[victim_r][index_req_r] <= tag_req_r;
      end
   end

   // State, latched miss request, pending flush and flush walk pointer.
   always_ff @(posedge clk) begin
      if (nrst) begin
         state_r      <= ST_IDLE;
         tag_req_r    <= '0;
         index_req_r  <= '0;
         victim_r     <= '0;
         flush_pend_r <= 1'b0;
         flush_idx_r  <= '0;
      end else begin
         state_r <= state_s;
         if (miss_latch_s) begin
            tag_req_r   <= bus.tag_C_L1;
            index_req_r <= bus.index_C_L1;
            victim_r    <= victim_sel_s;
         end
         if (state_r == ST_REFILL) begin
            flush_pend_r <= 1'b0;
         end else if ((state_r == ST_MISS) && bus.flush) begin
            flush_pend_r <= 1'b1;
         end
         if (flush_clr_s) begin
            flush_idx_r <= flush_idx_r + 1'b1;
         end
      end
   end

   assign req_addr_s      = {tag_req_r, index_req_r};
   assign bus.index_L1_L2 = req_addr_s[INUM_2-1:0];
   assign bus.tag_L1_L2   = req_addr_s[ADDR_BITS-1 -: TNUM_2];
   assign bus.stall       = stall_s;
   assign bus.refill      = refill_s;
   assign bus.hit         = hit_s;
   assign bus.way         = way_s;
   assign bus.read_L1_L2  = read_l2_s;
   assign bus.flush_done  = flush_done_s;
endmodule
